// File: rtl/seq_logic_pkg.sv
// Shared definitions for the seq_logic counter: default width and the
// wrapped-increment helper used by the count path.
package seq_logic_pkg;

    localparam int DEFAULT_WIDTH = 2;

    // Widest count the helper handles; the top level refuses wider instances.
    localparam int CNT_W = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    // The wrap is an explicit compare, so a terminal value that is not
    // 2**n-1 still returns to zero.
    function automatic cnt_t next_count(input cnt_t cur, input cnt_t max);
        cnt_t nxt;
        if (cur == max) begin
            nxt = '0;
        end else begin
            nxt = cur + cnt_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/seq_logic_tc_reg.sv
// Registered terminal-count detector: decodes the next count so the flag is
// high in the same cycle the count register holds the terminal value.
module seq_logic_tc_reg
    import seq_logic_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_COUNT = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] next_cnt_i,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_COUNT);

    logic done_q;
    logic done_d;

    always_comb begin
        done_d = (next_cnt_i == MAX_CNT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/seq_logic_counter.sv
// Free-running modulo-(MAX_COUNT+1) up-counter with a registered flag that is
// high exactly while the count sits at MAX_COUNT.
module seq_logic_counter
    import seq_logic_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_COUNT = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [WIDTH-1:0] q_out,
    output logic             done
);

    localparam logic [63:0] MAX_LEGAL = (64'd1 << WIDTH) - 64'd1;

    generate
        if (WIDTH < 1 || WIDTH > CNT_W) begin : g_bad_width
            $fatal(1, "seq_logic_counter: WIDTH %0d outside 1..%0d", WIDTH, CNT_W);
        end
        if (MAX_COUNT < 1 || 64'(MAX_COUNT) > MAX_LEGAL) begin : g_bad_max
            $fatal(1, "seq_logic_counter: MAX_COUNT %0d outside 1..2**%0d-1",
                   MAX_COUNT, WIDTH);
        end
    endgenerate

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             done_w;

    always_comb begin
        count_d = WIDTH'(next_count(cnt_t'(count_q), cnt_t'(MAX_COUNT)));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fed the next count, not the current one, so the flag lands with it.
    seq_logic_tc_reg #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) u_tc_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .next_cnt_i (count_d),
        .done_o     (done_w)
    );

    assign q_out = count_q;
    assign done  = done_w;

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_COUNT);

    a_done_at_max: assert property (@(posedge clk) disable iff (!reset_n)
        done |-> (q_out == MAX_CNT));

    a_max_has_done: assert property (@(posedge clk) disable iff (!reset_n)
        (q_out == MAX_CNT) |-> done);

    a_reset_clears: assert property (@(posedge clk)
        !reset_n |=> (q_out == '0) && !done);

endmodule

// File: tb/tb_seq_logic_counter.sv
// Directed bench for seq_logic_counter: default 2-bit instance plus a
// 3-bit instance wrapping at 4 to cover a non-power-of-two terminal value.
module tb_seq_logic_counter;

    logic       clk;
    logic       reset_n;
    logic [1:0] q_out;
    logic       done;
    logic [2:0] q5;
    logic       done5;

    int checks = 0;
    int errors = 0;

    seq_logic_counter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .q_out   (q_out),
        .done    (done)
    );

    seq_logic_counter #(.WIDTH(3), .MAX_COUNT(4)) dut5 (
        .clk     (clk),
        .reset_n (reset_n),
        .q_out   (q5),
        .done    (done5)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int rises;
        int exp_q;
        int exp_q5;
        logic prev_done;

        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_q", int'(q_out), 0);
            chk("rst_done", int'(done), 0);
        end

        reset_n = 1'b1;
        step(); chk("cnt1_q", int'(q_out), 1); chk("cnt1_done", int'(done), 0);
        step(); chk("cnt2_q", int'(q_out), 2); chk("cnt2_done", int'(done), 0);
        step(); chk("cnt3_q", int'(q_out), 3); chk("cnt3_done", int'(done), 1);
        step(); chk("wrap_q", int'(q_out), 0); chk("wrap_done", int'(done), 0);
        chk("m5_q", int'(q5), 4); chk("m5_done", int'(done5), 1);

        // 20 cycles: q walks 1,2,3,0,... so done rises on steps 3,7,11,15,19.
        rises     = 0;
        prev_done = done;
        exp_q     = 0;
        exp_q5    = 4;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_q  = (exp_q + 1) % 4;
            exp_q5 = (exp_q5 + 1) % 5;
            chk("run_q", int'(q_out), exp_q);
            chk("m5_run_q", int'(q5), exp_q5);
            chk("m5_run_done", int'(done5), (exp_q5 == 4) ? 1 : 0);
            if (done && !prev_done) begin
                rises++;
                chk("rise_q", int'(q_out), 3);
            end
            prev_done = done;
        end
        chk("rise_count", rises, 5);

        step(); step();
        chk("pre_rst_q", int'(q_out), 2);
        reset_n = 1'b0;
        step(); chk("mid_rst_q", int'(q_out), 0); chk("mid_rst_done", int'(done), 0);
        reset_n = 1'b1;
        step(); chk("restart1_q", int'(q_out), 1);
        step(); chk("restart2_q", int'(q_out), 2);
        step(); chk("restart3_q", int'(q_out), 3); chk("restart3_done", int'(done), 1);

        reset_n = 1'b0;
        step(); chk("tc_rst_q", int'(q_out), 0); chk("tc_rst_done", int'(done), 0);
        reset_n = 1'b1;
        step(); chk("post_tc1_q", int'(q_out), 1); chk("post_tc1_done", int'(done), 0);
        step(); chk("post_tc2_q", int'(q_out), 2); chk("post_tc2_done", int'(done), 0);
        step(); chk("post_tc3_q", int'(q_out), 3);
        step(); chk("post_tc4_q", int'(q_out), 0);

        // Low pulse strictly between edges must be ignored.
        #4 reset_n = 1'b0;
        #5 reset_n = 1'b1;
        step(); chk("glitch1_q", int'(q_out), 1);
        step(); chk("glitch2_q", int'(q_out), 2); chk("glitch2_done", int'(done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
